// File: rtl/arb_req_buffer_pkg.sv
// Shared types and constants for the request buffer that feeds the rotating
// priority selector. The entry struct sets the storage width of every slot,
// so DATA_W / STARVE_LIMIT overrides must be matched by these constants.
`ifndef SD
`define SD
`endif

package arb_req_buffer_pkg;

    localparam int ARB_WIDTH        = 16;
    localparam int ARB_DATA_W       = 32;
    localparam int ARB_STARVE_LIMIT = 15;
    localparam int ARB_AGE_W        = $clog2(ARB_STARVE_LIMIT + 1);

    // Index width for a WIDTH-entry vector; never narrower than one bit.
    function automatic int ARB_SRC_W(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    typedef struct packed {
        logic                  valid;
        logic [ARB_DATA_W-1:0] data;
        logic [ARB_AGE_W-1:0]  age;
    } req_entry_t;

endpackage

// File: rtl/arb_req_buffer_if.sv
// Selector handshake (req/en/gnt) and consumer transfer bus of the buffer.
interface arb_req_buffer_if
    import arb_req_buffer_pkg::*;
#(
    parameter int WIDTH  = ARB_WIDTH,
    parameter int DATA_W = ARB_DATA_W
);
    localparam int SRC_W = ARB_SRC_W(WIDTH);

    logic [WIDTH-1:0]  arb_req;
    logic              arb_en;
    logic [WIDTH-1:0]  arb_gnt;
    logic              out_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [SRC_W-1:0]  out_src;

    // Buffer side
    modport master (
        output arb_req, arb_en, out_valid, out_data, out_src,
        input  arb_gnt, out_ready
    );

    // Selector / consumer side
    modport slave (
        input  arb_req, arb_en, out_valid, out_data, out_src,
        output arb_gnt, out_ready
    );
endinterface

// File: rtl/arb_req_buffer_req_hold_slot.sv
// One pending-request entry: valid/data/age registers, push-over-take
// priority and the starvation compare.
module req_hold_slot
    import arb_req_buffer_pkg::*;
#(
    parameter int DATA_W       = ARB_DATA_W,
    parameter int STARVE_LIMIT = ARB_STARVE_LIMIT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              gnt_i,
    input  logic              en_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic              take_o,
    output logic              ready_o,
    output logic              starve_o
);
    localparam logic [ARB_AGE_W-1:0] AGE_MAX = ARB_AGE_W'(STARVE_LIMIT);

    req_entry_t entry_q, entry_d;
    logic       take;
    logic       load;

    // A grant only counts on a live entry while the selector is enabled.
    assign take     = gnt_i & en_i & entry_q.valid;
    assign ready_o  = ~entry_q.valid | take;
    assign load     = push_i & ready_o;
    assign take_o   = take;
    assign valid_o  = entry_q.valid;
    assign data_o   = entry_q.data;
    assign starve_o = entry_q.valid & (entry_q.age == AGE_MAX);

    // Next entry state: a load (including reload on take) wins over retire,
    // otherwise a waiting entry ages up to the saturation point.
    always_comb begin
        entry_d = entry_q;
        if (load) begin
            entry_d.valid = 1'b1;
            entry_d.data  = data_i;
            entry_d.age   = '0;
        end else if (take) begin
            entry_d.valid = 1'b0;
            entry_d.age   = '0;
        end else if (entry_q.valid && (entry_q.age != AGE_MAX)) begin
            entry_d.age = entry_q.age + ARB_AGE_W'(1);
        end
    end

    // Entry register with synchronous clear.
    always_ff @(posedge clock) begin
        if (reset) entry_q <= `SD '0;
        else       entry_q <= `SD entry_d;
    end

endmodule

// File: rtl/arb_req_buffer.sv
// Requester-side buffer for the rotating priority selector: one entry per
// source, retires the granted entry and emits its payload as a registered
// single-cycle transfer.
module arb_req_buffer
    import arb_req_buffer_pkg::*;
#(
    parameter int WIDTH        = ARB_WIDTH,
    parameter int DATA_W       = ARB_DATA_W,
    parameter int STARVE_LIMIT = ARB_STARVE_LIMIT
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [WIDTH-1:0]        push,
    input  logic [WIDTH*DATA_W-1:0] push_data,
    output logic [WIDTH-1:0]        ready,
    output logic [WIDTH-1:0]        starve,
    output logic                    starve_any,
    arb_req_buffer_if.master        bus
);
    localparam int SRC_W = ARB_SRC_W(WIDTH);

    logic [WIDTH-1:0]             valid;
    logic [WIDTH-1:0]             take;
    logic [WIDTH-1:0][DATA_W-1:0] slot_data;
    logic [DATA_W-1:0]            sel_data;
    logic [SRC_W-1:0]             sel_src;
    logic                         out_valid_q;
    logic [DATA_W-1:0]            out_data_q;
    logic [SRC_W-1:0]             out_src_q;

    // Entries only retire when the consumer can accept the transfer.
    assign bus.arb_en = bus.out_ready;

    for (genvar g = 0; g < WIDTH; g++) begin : g_slot
        req_hold_slot #(
            .DATA_W       (DATA_W),
            .STARVE_LIMIT (STARVE_LIMIT)
        ) u_slot (
            .clock    (clock),
            .reset    (reset),
            .push_i   (push[g]),
            .data_i   (push_data[g*DATA_W +: DATA_W]),
            .gnt_i    (bus.arb_gnt[g]),
            .en_i     (bus.arb_en),
            .valid_o  (valid[g]),
            .data_o   (slot_data[g]),
            .take_o   (take[g]),
            .ready_o  (ready[g]),
            .starve_o (starve[g])
        );
    end

    assign bus.arb_req = valid;
    assign starve_any  = |starve;

    // One-hot AND-OR payload mux and index encoder; take has at most one bit.
    always_comb begin
        sel_data = '0;
        sel_src  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sel_data = sel_data | (slot_data[i] & {DATA_W{take[i]}});
            sel_src  = sel_src  | (SRC_W'(i)    & {SRC_W{take[i]}});
        end
    end

    // Transfer register: pulse valid on a take, hold payload/index otherwise.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_q <= `SD 1'b0;
            out_data_q  <= `SD '0;
            out_src_q   <= `SD '0;
        end else begin
            out_valid_q <= `SD |take;
            if (|take) begin
                out_data_q <= `SD sel_data;
                out_src_q  <= `SD sel_src;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;

    // The selector must never grant more than one source per cycle.
    always @(posedge clock) begin
        if (!reset) begin
            assert ($onehot0(bus.arb_gnt))
            else $error("arb_gnt is not one-hot or zero: %b", bus.arb_gnt);
        end
    end

endmodule

// File: tb/tb_arb_req_buffer.sv
// Self-checking bench for arb_req_buffer: a directed vector table followed by
// hand-written multi-cycle sequences; transfer expectations go through a
// scoreboard queue when stimulus is driven and are popped at the output.
module tb_arb_req_buffer;
    localparam int W  = 16;
    localparam int DW = 32;
    localparam int SW = 4;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [W-1:0]    push  = '0;
    logic [W*DW-1:0] push_data = '0;
    wire  [W-1:0]    ready;
    wire  [W-1:0]    starve;
    wire             starve_any;

    arb_req_buffer_if #(.WIDTH(W), .DATA_W(DW)) bus ();

    arb_req_buffer #(.WIDTH(W), .DATA_W(DW), .STARVE_LIMIT(15)) dut (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .push_data  (push_data),
        .ready      (ready),
        .starve     (starve),
        .starve_any (starve_any),
        .bus        (bus.master)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
        logic [SW-1:0] s;
    } exp_t;

    typedef struct {
        logic [W-1:0]  push;
        logic [DW-1:0] d;
        logic [W-1:0]  gnt;
        logic          ordy;
        logic [W-1:0]  exp_rdy;
        logic          exp_v;
        logic [DW-1:0] exp_d;
        logic [SW-1:0] exp_s;
        logic [W-1:0]  exp_req;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[7];
    int   nvec = 0;
    int   nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and queue the transfer
    // the following rising edge must produce.
    task automatic drive(input logic [W-1:0] p, input logic [DW-1:0] d, input bit inc,
                         input logic [W-1:0] g, input logic r,
                         input logic ev, input logic [DW-1:0] ed, input logic [SW-1:0] es);
        @(negedge clock);
        push = p;
        for (int i = 0; i < W; i++)
            push_data[i*DW +: DW] = p[i] ? (inc ? d + DW'(i) : d) : '0;
        bus.arb_gnt   = g;
        bus.out_ready = r;
        sb.push_back('{ev, ed, es});
        #1;
    endtask

    task automatic clk_out(input string tag);
        exp_t e;
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            nvec++;
            nerr++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(e.v));
            chk({tag, ".out_data"},  bus.out_data,       e.d);
            chk({tag, ".out_src"},   32'(bus.out_src),   32'(e.s));
        end
    endtask

    initial begin
        logic [31:0] m;

        tbl[0] = '{16'h0008, 32'hA5A5_0003, 16'h0000, 1'b1, 16'hFFFF, 1'b0, 32'h0,          4'd0, 16'h0008};
        tbl[1] = '{16'h0000, 32'h0,         16'h0008, 1'b1, 16'hFFFF, 1'b1, 32'hA5A5_0003, 4'd3, 16'h0000};
        tbl[2] = '{16'h0000, 32'h0,         16'h0000, 1'b1, 16'hFFFF, 1'b0, 32'hA5A5_0003, 4'd3, 16'h0000};
        tbl[3] = '{16'h0000, 32'h0,         16'h0200, 1'b1, 16'hFFFF, 1'b0, 32'hA5A5_0003, 4'd3, 16'h0000};
        tbl[4] = '{16'h0004, 32'h0000_0022, 16'h0000, 1'b1, 16'hFFFF, 1'b0, 32'hA5A5_0003, 4'd3, 16'h0004};
        tbl[5] = '{16'h0000, 32'h0,         16'h0004, 1'b0, 16'hFFFB, 1'b0, 32'hA5A5_0003, 4'd3, 16'h0004};
        tbl[6] = '{16'h0000, 32'h0,         16'h0004, 1'b1, 16'hFFFF, 1'b1, 32'h0000_0022, 4'd2, 16'h0000};

        bus.arb_gnt   = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rst.out_valid",  32'(bus.out_valid), 32'd0);
        chk("rst.out_data",   bus.out_data,       32'd0);
        chk("rst.out_src",    32'(bus.out_src),   32'd0);
        chk("rst.arb_req",    32'(bus.arb_req),   32'h0);
        chk("rst.ready",      32'(ready),         32'hFFFF);
        chk("rst.starve",     32'(starve),        32'h0);
        chk("rst.starve_any", 32'(starve_any),    32'd0);

        // Directed vectors: single transfer, hold, invalid grant, disabled grant.
        for (int k = 0; k < 7; k++) begin
            drive(tbl[k].push, tbl[k].d, 1'b0, tbl[k].gnt, tbl[k].ordy,
                  tbl[k].exp_v, tbl[k].exp_d, tbl[k].exp_s);
            chk($sformatf("vec%0d.ready", k),  32'(ready),      32'(tbl[k].exp_rdy));
            chk($sformatf("vec%0d.arb_en", k), 32'(bus.arb_en), 32'(tbl[k].ordy));
            clk_out($sformatf("vec%0d", k));
            chk($sformatf("vec%0d.arb_req", k), 32'(bus.arb_req), 32'(tbl[k].exp_req));
        end

        // All sources push together, then drain 0..15 back to back.
        drive('1, 32'hD000_0000, 1'b1, '0, 1'b1, 1'b0, 32'h0000_0022, 4'd2);
        clk_out("burst.push");
        chk("burst.arb_req", 32'(bus.arb_req), 32'hFFFF);
        for (int k = 0; k < W; k++) begin
            drive('0, '0, 1'b0, W'(1) << k, 1'b1, 1'b1, 32'hD000_0000 + 32'(k), SW'(k));
            m = (32'd1 << (k + 1)) - 32'd1;
            chk($sformatf("burst%0d.ready", k), 32'(ready), {16'h0, m[15:0]});
            clk_out($sformatf("burst%0d", k));
        end
        chk("burst.ready_after",   32'(ready),       32'hFFFF);
        chk("burst.arb_req_after", 32'(bus.arb_req), 32'h0);

        // Reload on take: old payload leaves, new one starts at age 0.
        drive(16'h0020, 32'h11, 1'b0, '0, 1'b1, 1'b0, 32'hD000_000F, 4'd15);
        clk_out("reload.push");
        drive(16'h0020, 32'h55, 1'b0, 16'h0020, 1'b1, 1'b1, 32'h11, 4'd5);
        chk("reload.ready5", 32'(ready[5]), 32'd1);
        clk_out("reload.take");
        chk("reload.arb_req", 32'(bus.arb_req), 32'h0020);
        for (int j = 1; j <= 16; j++) begin
            drive('0, '0, 1'b0, '0, 1'b1, 1'b0, 32'h11, 4'd5);
            chk($sformatf("reload.age%0d.starve5", j), 32'(starve[5]), 32'(j >= 16));
            clk_out($sformatf("reload.age%0d", j));
        end
        drive('0, '0, 1'b0, 16'h0020, 1'b1, 1'b1, 32'h55, 4'd5);
        clk_out("reload.drain");
        chk("reload.starve_after", 32'(starve), 32'h0);

        // Consumer stalled 20 cycles with a grant pending on source 7.
        drive(16'h0080, 32'h77, 1'b0, '0, 1'b1, 1'b0, 32'h55, 4'd5);
        clk_out("stall.push");
        for (int j = 1; j <= 20; j++) begin
            drive('0, '0, 1'b0, 16'h0080, 1'b0, 1'b0, 32'h55, 4'd5);
            chk($sformatf("stall%0d.starve7", j),    32'(starve[7]),  32'(j >= 16));
            chk($sformatf("stall%0d.starve_any", j), 32'(starve_any), 32'(j >= 16));
            clk_out($sformatf("stall%0d", j));
        end
        drive('0, '0, 1'b0, 16'h0080, 1'b1, 1'b1, 32'h77, 4'd7);
        chk("stall.release.arb_en", 32'(bus.arb_en), 32'd1);
        clk_out("stall.release");
        chk("stall.starve_after",     32'(starve),      32'h0);
        chk("stall.starve_any_after", 32'(starve_any),  32'd0);
        chk("stall.arb_req_after",    32'(bus.arb_req), 32'h0);

        // Reset with four entries pending discards them silently.
        drive(16'h1111, 32'hEE, 1'b0, '0, 1'b1, 1'b0, 32'h77, 4'd7);
        clk_out("midrst.push");
        chk("midrst.arb_req_before", 32'(bus.arb_req), 32'h1111);
        @(negedge clock);
        reset         = 1'b1;
        push          = '0;
        bus.arb_gnt   = 16'h0001;
        bus.out_ready = 1'b1;
        @(posedge clock);
        #1;
        chk("midrst.out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst.out_data",  bus.out_data,       32'd0);
        chk("midrst.arb_req",   32'(bus.arb_req),   32'h0);
        chk("midrst.ready",     32'(ready),         32'hFFFF);
        reset = 1'b0;
        drive('0, '0, 1'b0, 16'h0001, 1'b1, 1'b0, 32'h0, 4'd0);
        clk_out("midrst.after");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/arb_req_buffer.md
# arb_req_buffer

Requester-side companion to the rotating priority selector. It holds one pending request plus payload per source and drives the selector's `req` vector and `en`. When the selector's one-hot `gnt` comes back, it retires the granted entry and emits the entry's payload and source index as a registered, single-cycle transfer to the consumer. Per-entry age counters flag sources that wait too long.

## Interface
Parameters:
- WIDTH, 16, number of sources and width of the req/gnt vectors
- DATA_W, 32, payload width per source
- STARVE_LIMIT, 15, wait-cycle count at which an entry is flagged starved (must be at least 1)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- push  in  WIDTH  per-source request strobe
- push_data  in  WIDTH*DATA_W  payloads; source i occupies bits [i*DATA_W +: DATA_W]
- ready  out  WIDTH  per-source accept, combinational
- arb_req  out  WIDTH  valid bit per entry, to the selector's req
- arb_en  out  1  selector enable; equals out_ready
- arb_gnt  in  WIDTH  one-hot (or zero) grant from the selector, same cycle
- out_ready  in  1  consumer can take a transfer next cycle
- out_valid  out  1  registered transfer strobe
- out_data  out  DATA_W  granted payload
- out_src  out  $clog2(WIDTH)  index of the granted source
- starve  out  WIDTH  entry i has reached STARVE_LIMIT
- starve_any  out  1  OR of starve

## Operation
- Per-entry state: valid, data[DATA_W], age[$clog2(STARVE_LIMIT+1)].
- arb_req[i] = valid[i].
- take[i] = arb_gnt[i] & valid[i] & arb_en.
  - Grant bits on invalid entries are ignored.
  - Any grant while arb_en = 0 is ignored.
- ready[i] = !valid[i] | take[i].
  - A push while ready[i] = 0 is dropped. Sources must hold push until they see ready.
- Per-entry next state, in priority order:
  - push[i] & ready[i]: valid = 1, data = push_data slice, age = 0. This covers reload in the same cycle as take.
  - else take[i]: valid = 0, age = 0.
  - else valid[i]: age = min(age + 1, STARVE_LIMIT).
- starve[i] = valid[i] & (age[i] == STARVE_LIMIT).
- Output register:
  - When any take: out_valid = 1, out_data = data of the taken entry (pre-update value), out_src = its index.
  - Otherwise out_valid = 0; out_data and out_src hold their previous values.
- arb_gnt must be one-hot or zero. More than one set bit is a protocol error and triggers a simulation assertion. The RTL result in that case is don't-care.

## Timing
- Reset values: valid = 0, age = 0, out_valid = 0, out_data = 0, out_src = 0. Consequently arb_req = 0, starve = 0, ready = all ones.
- Reset mid-operation discards every pending entry without emitting it.
- Push accepted at edge N: arb_req bit is high in cycle N+1. The earliest possible grant is in cycle N+1.
- Grant in cycle G, with arb_en = 1: out_valid is high for exactly cycle G+1, and the entry is free in G+1.
  - If the same source pushed in G, the entry instead holds the new payload in G+1.
- Throughput: one transfer per cycle while out_ready stays high.
- out_ready low: arb_en is low, so no entry retires and no grant is consumed. Ages continue to increment.
- Age counts cycles spent valid and not taken. It saturates and never wraps.

## Structure
- Shared package holds the `req_entry_t` struct {valid, data, age} and the `ARB_SRC_W` = $clog2(WIDTH) helper.
- Sub-module `req_hold_slot`: one entry, covering the valid/data/age registers, push/take priority and the starve compare. Instantiated WIDTH times via generate.
- Top level contains:
  - the one-hot payload mux (AND-OR);
  - the one-hot-to-index encoder for out_src;
  - the output register;
  - the one-hot assertion.
- All flops use the `SD` delay macro.

## Test plan
- Reset, then push on source 3 with data 0xA5A5_0003; grant bit 3 in the next cycle with out_ready = 1 → out_valid pulses one cycle with out_data = 0xA5A5_0003 and out_src = 3; arb_req[3] falls.
- All 16 sources push at once; model selector grants 0,1,…,15 on consecutive cycles → 16 back-to-back out_valid cycles in that order; ready is all ones afterward.
- Source 5 pending, with a grant on 5 and a new push on 5 (data 0x55) in the same cycle → old payload is emitted; entry stays valid holding 0x55 with age 0.
- out_ready held at 0 for 20 cycles with source 7 pending and a grant asserted → no out_valid; starve[7] rises after 15 cycles and starve_any = 1; after out_ready returns to 1, the transfer occurs and starve[7] clears.
- Grant on an invalid entry 9 → no out_valid, no state change; reset asserted with 4 entries pending → all cleared and out_valid stays 0.
